mem_port_arbiter: RTL and testbench

Arbitrates port A of the shared dual-port data/instruction RAM between two masters: the multicycle CPU control path and an I/O/DMA master such as a program loader or display reader. Each granted access is a single word. The CPU has fixed priority, with a starvation guard so the I/O master cannot be locked out. The block sits between both masters and the RAM's port A address, data, write-enable and q signals.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares port A of the data/instruction RAM between the CPU control path
//   and an I/O/DMA master. Each grant covers one word. The CPU has fixed
//   priority. A starvation counter forces an I/O win after STARVE_MAX
//   consecutive CPU wins taken while I/O was also waiting. Only one access
//   is in flight at any time.
//
// Ports
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   cpu_req/we/addr/wdata   : CPU request; held stable until cpu_gnt
//   io_req/we/addr/wdata    : I/O request; held stable until io_gnt
//   cpu_gnt, io_gnt         : one-cycle pulse in the ISSUE cycle
//   cpu_rvalid, io_rvalid   : one-cycle pulse; matching rdata is valid
//   cpu_rdata, io_rdata     : registered read data, held until that master's next read
//   mem_addr/wdata/wren     : RAM port A drive
//   mem_q                   : RAM port A read data
//   busy                    : high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              cpu_gnt,
  output logic              io_gnt,
  output logic              cpu_rvalid,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam logic [2:0] LAT_INIT   = 3'(RD_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;   // 0 = CPU, 1 = I/O
  logic        op_rd, op_rd_nxt;
  logic [2:0]  lat_cnt, lat_cnt_nxt;
  logic [3:0]  starve_cnt, starve_cnt_nxt;
  logic        io_win;
  logic        rd_done;

  // The owner's request fields stay stable through ISSUE and WAIT, so they
  // can be steered straight onto the RAM port without an extra register.
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  assign sel_addr  = owner ? io_addr  : cpu_addr;
  assign sel_wdata = owner ? io_wdata : cpu_wdata;
  assign sel_we    = owner ? io_we    : cpu_we;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      op_rd      <= 1'b0;
      lat_cnt    <= 3'd0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      op_rd      <= op_rd_nxt;
      lat_cnt    <= lat_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Read return: capture mem_q on the final WAIT edge into the owner's
  // holding register and raise that owner's rvalid for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      io_rdata   <= '0;
    end else begin
      cpu_rvalid <= rd_done && !owner;
      io_rvalid  <= rd_done && owner;
      if (rd_done && !owner) cpu_rdata <= mem_q;
      if (rd_done && owner)  io_rdata  <= mem_q;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    op_rd_nxt      = op_rd;
    lat_cnt_nxt    = lat_cnt;
    starve_cnt_nxt = starve_cnt;
    io_win         = 1'b0;
    rd_done        = 1'b0;
    cpu_gnt        = 1'b0;
    io_gnt         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wren       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req || io_req) begin
          io_win    = io_req && (!cpu_req || (starve_cnt == STARVE_LIM));
          owner_nxt = io_win;
          op_rd_nxt = io_win ? ~io_we : ~cpu_we;
          state_nxt = ST_ISSUE;
          // Only CPU wins taken over a waiting I/O request count toward
          // starvation; the counter saturates at the limit.
          if (io_win) begin
            starve_cnt_nxt = 4'd0;
          end else if (io_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
          end
        end
      end

      ST_ISSUE: begin
        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
        mem_wren  = sel_we;
        cpu_gnt   = !owner;
        io_gnt    = owner;
        if (op_rd) begin
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = ST_WAIT;
        end else begin
          state_nxt   = ST_IDLE;
        end
      end

      ST_WAIT: begin
        mem_addr    = sel_addr;
        lat_cnt_nxt = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with default parameters
//   (RD_LAT = 2, STARVE_MAX = 3). A small behavioural RAM with a registered
//   address and registered output gives the two-cycle read latency.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic        cpu_gnt, io_gnt, cpu_rvalid, io_rvalid;
  logic [15:0] cpu_rdata, io_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_q;
  logic        mem_wren, busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .RD_LAT(2), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .cpu_gnt(cpu_gnt), .io_gnt(io_gnt),
    .cpu_rvalid(cpu_rvalid), .io_rvalid(io_rvalid),
    .cpu_rdata(cpu_rdata), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address registered on one edge, data registered on the next.
  logic [15:0] ram [0:1023];
  logic [9:0]  ram_addr_r;
  logic [15:0] ram_q_r;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[9:0]] <= mem_wdata;
    ram_addr_r <= mem_addr[9:0];
    ram_q_r    <= ram[ram_addr_r];
  end
  assign mem_q = ram_q_r;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    ram[16] = 16'hBEEF;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = 16'h0; io_wdata  = 16'h0;

    // Reset state
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    rst_n = 1'b1;

    // CPU read of 0x0010 -> 0xBEEF; cycle T is this cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    tick(1);                                   // T+1
    check("t1_cpu_gnt", cpu_gnt, 1);
    check("t1_io_gnt", io_gnt, 0);
    check("t1_addr_issue", mem_addr, 16'h0010);
    check("t1_wren_issue", mem_wren, 0);
    check("t1_busy", busy, 1);
    cpu_req = 1'b0;
    tick(1);                                   // T+2
    check("t1_gnt_once", cpu_gnt, 0);
    check("t1_addr_wait0", mem_addr, 16'h0010);
    tick(1);                                   // T+3
    check("t1_addr_wait1", mem_addr, 16'h0010);
    check("t1_rvalid_early", cpu_rvalid, 0);
    tick(1);                                   // T+4
    check("t1_rvalid", cpu_rvalid, 1);
    check("t1_rdata", cpu_rdata, 16'hBEEF);
    check("t1_io_rvalid", io_rvalid, 0);
    check("t1_busy_idle", busy, 0);
    check("t1_addr_idle", mem_addr, 0);
    tick(1);
    check("t1_rvalid_pulse", cpu_rvalid, 0);
    check("t1_rdata_hold", cpu_rdata, 16'hBEEF);

    // I/O write 0x1234 to 0x0100, then CPU read it back
    io_req = 1'b1; io_we = 1'b1; io_addr = 16'h0100; io_wdata = 16'h1234;
    tick(1);
    check("t2_io_gnt", io_gnt, 1);
    check("t2_cpu_gnt", cpu_gnt, 0);
    check("t2_wren", mem_wren, 1);
    check("t2_addr", mem_addr, 16'h0100);
    check("t2_wdata", mem_wdata, 16'h1234);
    io_req = 1'b0;
    tick(1);
    check("t2_wren_once", mem_wren, 0);
    check("t2_io_gnt_once", io_gnt, 0);
    check("t2_busy", busy, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    tick(1);
    check("t2_rd_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick(3);
    check("t2_rd_rvalid", cpu_rvalid, 1);
    check("t2_rd_rdata", cpu_rdata, 16'h1234);

    // Simultaneous reads: CPU first, I/O after the CPU access completes
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 16'h0100;
    tick(1);
    check("t3_cpu_first", cpu_gnt, 1);
    check("t3_io_not_first", io_gnt, 0);
    cpu_req = 1'b0;
    tick(3);
    check("t3_cpu_rvalid", cpu_rvalid, 1);
    check("t3_cpu_rdata", cpu_rdata, 16'hBEEF);
    check("t3_io_wait", io_gnt, 0);
    tick(1);
    check("t3_io_gnt", io_gnt, 1);
    check("t3_io_addr", mem_addr, 16'h0100);
    io_req = 1'b0;
    tick(3);
    check("t3_io_rvalid", io_rvalid, 1);
    check("t3_io_rdata", io_rdata, 16'h1234);
    check("t3_cpu_rvalid_off", cpu_rvalid, 0);

    // Back-to-back CPU writes with I/O read pending: 3 CPU wins then I/O
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'hAAAA;
    io_req  = 1'b1; io_we  = 1'b0; io_addr  = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check($sformatf("t4_cpu_gnt%0d", k), cpu_gnt, 1);
      check($sformatf("t4_io_held%0d", k), io_gnt, 0);
      check($sformatf("t4_wren%0d", k), mem_wren, 1);
      tick(1);
      check($sformatf("t4_gap%0d", k), cpu_gnt, 0);
    end
    tick(1);
    check("t4_io_forced", io_gnt, 1);
    check("t4_cpu_lose", cpu_gnt, 0);
    io_req = 1'b0;
    tick(2);
    check("t4_cpu_ignored", cpu_gnt, 0);
    tick(1);
    check("t4_io_rvalid", io_rvalid, 1);
    check("t4_io_rdata", io_rdata, 16'hBEEF);
    tick(1);
    check("t4_cpu_resume", cpu_gnt, 1);
    io_req = 1'b1; io_we = 1'b1; io_addr = 16'h0030; io_wdata = 16'h0000;
    tick(2);
    // Starvation counter was cleared, so the CPU wins again here
    check("t4_starve_clr_cpu", cpu_gnt, 1);
    check("t4_starve_clr_io", io_gnt, 0);
    cpu_req = 1'b0; io_req = 1'b0;
    tick(1);

    // Reset during WAIT of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    tick(1);
    check("t5_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick(1);
    check("t5_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_busy_rst", busy, 0);
    check("t5_addr_rst", mem_addr, 0);
    check("t5_rdata_rst", cpu_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check($sformatf("t5_no_rvalid%0d", k), cpu_rvalid, 0);
    end
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    tick(1);
    check("t5_new_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick(3);
    check("t5_new_rvalid", cpu_rvalid, 1);
    check("t5_new_rdata", cpu_rdata, 16'h1234);

    // io_req raised during ISSUE of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    tick(1);
    check("t6_cpu_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    io_req = 1'b1; io_we = 1'b1; io_addr = 16'h0030; io_wdata = 16'h5555;
    tick(1);
    check("t6_io_blocked0", io_gnt, 0);
    tick(1);
    check("t6_io_blocked1", io_gnt, 0);
    tick(1);
    check("t6_cpu_rvalid", cpu_rvalid, 1);
    check("t6_io_blocked2", io_gnt, 0);
    tick(1);
    check("t6_io_gnt", io_gnt, 1);
    check("t6_io_wren", mem_wren, 1);
    check("t6_io_wdata", mem_wdata, 16'h5555);
    io_req = 1'b0;
    tick(1);
    check("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
